// File: rtl/fill_rect_pkg.sv
// rtl/fill_rect_pkg.sv - shared types and helpers for the rectangle fill engine
package fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M_SOLID,
    M_COLSTRIPE,
    M_ROWSTRIPE,
    M_CHECKER
  } mode_t;

  function automatic int unsigned clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fill_rect_if.sv
// rtl/fill_rect_if.sv - controller-side request and VGA-side pixel stream of the fill engine
interface fill_rect_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W-1:0]      x1;
  logic [Y_W-1:0]      y1;
  logic [COLOUR_W-1:0] colour;
  logic [1:0]          mode;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, x0, y0, x1, y1, colour, mode,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x0, y0, x1, y1, colour, mode,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/fill_rect_scan_ctr.sv
// rtl/fill_rect_scan_ctr.sv - clamped/ordered rectangle bounds and column-major x/y scan counter
module fill_scan_ctr
  import fill_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_x1,
  input  logic [Y_W-1:0] i_y1,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x, r_xl, r_xh;
  logic [Y_W-1:0] r_y, r_yl, r_yh;

  logic [X_W-1:0] w_cx0, w_cx1, w_xl, w_xh;
  logic [Y_W-1:0] w_cy0, w_cy1, w_yl, w_yh;

  // Clamp first so an out-of-range corner still orders correctly against the other.
  assign w_cx0 = X_W'(clamp(32'(i_x0), SCREEN_W - 1));
  assign w_cx1 = X_W'(clamp(32'(i_x1), SCREEN_W - 1));
  assign w_cy0 = Y_W'(clamp(32'(i_y0), SCREEN_H - 1));
  assign w_cy1 = Y_W'(clamp(32'(i_y1), SCREEN_H - 1));

  assign w_xl = (w_cx0 < w_cx1) ? w_cx0 : w_cx1;
  assign w_xh = (w_cx0 < w_cx1) ? w_cx1 : w_cx0;
  assign w_yl = (w_cy0 < w_cy1) ? w_cy0 : w_cy1;
  assign w_yh = (w_cy0 < w_cy1) ? w_cy1 : w_cy0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_xl <= '0;
      r_xh <= '0;
      r_yl <= '0;
      r_yh <= '0;
    end else if (i_load) begin
      r_x  <= w_xl;
      r_y  <= w_yl;
      r_xl <= w_xl;
      r_xh <= w_xh;
      r_yl <= w_yl;
      r_yh <= w_yh;
    end else if (i_step) begin
      if (r_y == r_yh) begin
        r_y <= r_yl;
        r_x <= r_x + X_W'(1);
      end else begin
        r_y <= r_y + Y_W'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_xh) && (r_y == r_yh);

endmodule

// File: rtl/fill_rect.sv
// rtl/fill_rect.sv - paints an axis-aligned framebuffer rectangle, one pixel per clock, column-major
module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic  clk,
  input  logic  rst,
  fill_rect_if.slave bus
);

  state_t              r_state, w_next;
  logic                w_load, w_step, w_last;
  logic [COLOUR_W-1:0] r_colour, w_colour;
  mode_t               r_mode;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;

  fill_scan_ctr #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_step(w_step),
    .i_x0  (bus.x0),
    .i_y0  (bus.y0),
    .i_x1  (bus.x1),
    .i_y1  (bus.y1),
    .o_x   (w_x),
    .o_y   (w_y),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        if (w_last) w_next = DONE;
        else        w_step = 1'b1;
      end
      DONE: begin
        if (!bus.start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_colour <= '0;
      r_mode   <= M_SOLID;
    end else if (w_load) begin
      r_colour <= bus.colour;
      r_mode   <= mode_t'(bus.mode);
    end
  end

  // Colour follows the live scan position, so in DONE it still reflects the last pixel.
  always_comb begin
    w_colour = r_colour;
    case (r_mode)
      M_COLSTRIPE: w_colour = r_colour + w_x[COLOUR_W-1:0];
      M_ROWSTRIPE: w_colour = r_colour + w_y[COLOUR_W-1:0];
      M_CHECKER:   if (w_x[0] ^ w_y[0]) w_colour = ~r_colour;
      default:     w_colour = r_colour;
    endcase
  end

  assign bus.vga_x      = w_x;
  assign bus.vga_y      = w_y;
  assign bus.vga_colour = w_colour;
  assign bus.vga_plot   = (r_state == FILL);
  assign bus.done       = (r_state == DONE);

endmodule
